// File: rtl/fifo_readout_arbiter.sv
// fifo_readout_arbiter
//   Merges N_SRC first-word-fall-through source FIFOs into one FWFT read port.
//   Sources are granted round-robin. Each grant lasts up to MAX_BURST pops.
//   Merged words pass through a 2-entry output queue.
//
// Ports
//   BUS_CLK         in   clock, rising edge
//   BUS_RST         in   asynchronous reset, active low
//   SRC_EN          in   per-source enable mask
//   SRC_FIFO_EMPTY  in   per-source empty flags
//   SRC_FIFO_DATA   in   per-source head words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   SRC_FIFO_READ   out  per-source pop strobes (one-hot or zero, combinational)
//   FIFO_READ       in   consumer pop strobe
//   FIFO_EMPTY      out  merged queue empty
//   FIFO_DATA       out  merged queue head word (registered)
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | search for the next eligible source after the rr pointer; no pop
// BURST  | pop the granted source while enabled, non-empty and queue not full

module fifo_readout_arbiter #(
    parameter int N_SRC      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                        BUS_CLK,
    input  logic                        BUS_RST,
    input  logic [N_SRC-1:0]            SRC_EN,
    input  logic [N_SRC-1:0]            SRC_FIFO_EMPTY,
    input  logic [N_SRC*DATA_WIDTH-1:0] SRC_FIFO_DATA,
    output logic [N_SRC-1:0]            SRC_FIFO_READ,
    input  logic                        FIFO_READ,
    output logic                        FIFO_EMPTY,
    output logic [DATA_WIDTH-1:0]       FIFO_DATA
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   grant, grant_nxt;       // also serves as the round-robin pointer
    logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
    logic [1:0]      count;
    logic [DATA_WIDTH-1:0] tail;

    logic            found;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   idx;
    logic            src_ok;
    logic            src_pop;
    logic            q_pop;
    logic [DATA_WIDTH-1:0] push_data;

    // Round-robin search starting just after the last grant, wrapping.
    always_comb begin
        found = 1'b0;
        cand  = grant;
        idx   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            idx = IW'((int'(grant) + i) % N_SRC);
            if (!found && SRC_EN[idx] && !SRC_FIFO_EMPTY[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end

    assign src_ok    = SRC_EN[grant] & ~SRC_FIFO_EMPTY[grant];
    assign src_pop   = (state == BURST) && src_ok && (count != 2'd2);
    assign q_pop     = FIFO_READ && (count != 2'd0);
    assign push_data = SRC_FIFO_DATA[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            state     <= IDLE;
            grant     <= IW'(N_SRC - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        burst_cnt_nxt = burst_cnt;
        SRC_FIFO_READ = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt     = cand;
                    burst_cnt_nxt = '0;
                    state_nxt     = BURST;
                end
            end
            BURST: begin
                if (src_pop) begin
                    SRC_FIFO_READ[grant] = 1'b1;
                    burst_cnt_nxt        = burst_cnt + 1'b1;
                end
                // A full queue only stalls; the burst ends on its last pop,
                // an empty source or a disabled source.
                if ((src_pop && burst_cnt == CW'(MAX_BURST - 1)) || !src_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output queue: FIFO_DATA is the head register, tail holds the second word.
    // A push is only possible below count 2, so push+pop only happens at count 1.
    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            count     <= 2'd0;
            FIFO_DATA <= '0;
            tail      <= '0;
        end else if (src_pop && q_pop) begin
            FIFO_DATA <= push_data;
        end else if (src_pop) begin
            if (count == 2'd0) begin
                FIFO_DATA <= push_data;
            end else begin
                tail <= push_data;
            end
            count <= count + 2'd1;
        end else if (q_pop) begin
            if (count == 2'd2) begin
                FIFO_DATA <= tail;
            end
            count <= count - 2'd1;
        end
    end

    assign FIFO_EMPTY = (count == 2'd0);

endmodule

// File: tb/tb_fifo_readout_arbiter.sv
// Directed testbench for fifo_readout_arbiter (3 sources, 16-bit words, bursts of 4).
// The source FIFOs are modelled as queues. Expected output words go into a scoreboard
// queue and are compared at every consumer pop.
module tb_fifo_readout_arbiter;
    localparam int NS = 3;
    localparam int W  = 16;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     src_en;
    logic [NS-1:0]     src_empty;
    logic [NS*W-1:0]   src_data;
    logic [NS-1:0]     src_read;
    logic              fifo_read;
    logic              fifo_empty;
    logic [W-1:0]      fifo_data;

    always #5 clk = ~clk;

    fifo_readout_arbiter #(.N_SRC(NS), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
        .BUS_CLK       (clk),
        .BUS_RST       (rst_n),
        .SRC_EN        (src_en),
        .SRC_FIFO_EMPTY(src_empty),
        .SRC_FIFO_DATA (src_data),
        .SRC_FIFO_READ (src_read),
        .FIFO_READ     (fifo_read),
        .FIFO_EMPTY    (fifo_empty),
        .FIFO_DATA     (fifo_data)
    );

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  src_q[NS][$];
    logic [W-1:0]  exp_q[$];
    int            pop_src[$];
    int            pop_cyc[$];
    int            cyc = 0;
    bit            sb_auto = 1'b0;
    logic [NS-1:0] last_rd = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NS; i++) begin
            src_empty[i]       = (src_q[i].size() == 0);
            src_data[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic load(input int s, input logic [W-1:0] base, input int n, input bit expect_it);
        for (int k = 0; k < n; k++) begin
            src_q[s].push_back(base + W'(k));
            if (expect_it) exp_q.push_back(base + W'(k));
        end
        refresh();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        pop_src.delete();
        pop_cyc.delete();
        refresh();
    endtask

    // One clock: sample at the falling edge, model the pops at the rising edge.
    task automatic step();
        logic [NS-1:0] rd;
        logic          cons;
        logic [W-1:0]  dout;
        logic [W-1:0]  v;
        @(negedge clk);
        rd   = src_read;
        cons = fifo_read && !fifo_empty;
        dout = fifo_data;
        if (rd != '0) begin
            checks++;
            assert ($onehot(rd) && ((rd & ~(src_en & ~src_empty)) == '0)) else begin
                errors++;
                $error("FAIL src_read_legal: observed=%b allowed=%b", rd, src_en & ~src_empty);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        last_rd = rd;
        for (int i = 0; i < NS; i++) begin
            if (rd[i] && src_q[i].size() != 0) begin
                v = src_q[i].pop_front();
                if (sb_auto) exp_q.push_back(v);
                pop_src.push_back(i);
                pop_cyc.push_back(cyc);
            end
        end
        if (cons) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed=%0h expected=none", dout);
            end
            if (exp_q.size() != 0) check("fifo_data", dout, exp_q.pop_front());
        end
        refresh();
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && fifo_empty && ((src_en & ~src_empty) == '0)) && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL %s_timeout: observed=%0d cycles expected=<%0d", tag, n, budget);
        end
        repeat (3) step();
        check({tag, "_empty_after"}, W'(fifo_empty), W'(1'b1));
    endtask

    initial begin
        int n;
        int nsrc1;
        int e2[12];
        int e5[14];
        e2 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
        e5 = '{2, 2, 2, 2, 0, 0, 0, 0, 2, 2, 2, 2, 0, 0};

        rst_n     = 1'b0;
        fifo_read = 1'b0;
        src_en    = '0;
        clear_all();
        #1;
        check("reset_empty", W'(fifo_empty), W'(1'b1));
        check("reset_data", fifo_data, '0);
        check("reset_src_read", W'(src_read), '0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a burst with a full queue
        src_en = 3'b001;
        load(0, 16'h1000, 6, 1'b0);
        repeat (5) step();
        check("t1_pops_before_full", W'(pop_src.size()), W'(2));
        check("t1_full_not_empty", W'(fifo_empty), W'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_rst_empty", W'(fifo_empty), W'(1'b1));
        check("t1_rst_data", fifo_data, '0);
        check("t1_rst_src_read", W'(src_read), '0);
        clear_all();
        src_en    = 3'b111;
        fifo_read = 1'b1;
        load(0, 16'h1100, 1, 1'b1);
        load(1, 16'h1200, 1, 1'b1);
        load(2, 16'h1300, 1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drain(40, "t1");
        check("t1_first_grant", W'(pop_src.size() > 0 ? pop_src[0] : 99), W'(0));

        // Two sources, bursts of 4, consumer always reading
        clear_all();
        src_en = 3'b011;
        load(0, 16'hA000, 6, 1'b0);
        load(1, 16'hB000, 6, 1'b0);
        for (int k = 0; k < 4; k++) exp_q.push_back(16'hA000 + W'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(16'hB000 + W'(k));
        exp_q.push_back(16'hA004);
        exp_q.push_back(16'hA005);
        exp_q.push_back(16'hB004);
        exp_q.push_back(16'hB005);
        drain(80, "t2");
        check("t2_pop_count", W'(pop_src.size()), W'(12));
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t2_pop_src_%0d", k), W'(k < pop_src.size() ? pop_src[k] : 99), W'(e2[k]));
        end
        if (pop_cyc.size() == 12) begin
            check("t2_gap_a3_b0", W'(pop_cyc[4] - pop_cyc[3]), W'(2));
            check("t2_gap_b3_a4", W'(pop_cyc[8] - pop_cyc[7]), W'(2));
        end

        // Single source, consumer stalled, then released
        clear_all();
        fifo_read = 1'b0;
        src_en    = 3'b100;
        load(2, 16'h3000, 3, 1'b0);
        repeat (6) step();
        check("t3_pops_stalled", W'(pop_src.size()), W'(2));
        check("t3_head", fifo_data, 16'h3000);
        check("t3_not_empty", W'(fifo_empty), W'(1'b0));
        fifo_read = 1'b1;
        exp_q.push_back(16'h3000);
        exp_q.push_back(16'h3001);
        exp_q.push_back(16'h3002);
        step();
        step();
        check("t3_third_pop_after_consume", W'(last_rd), W'(3'b100));
        drain(40, "t3");
        check("t3_total_pops", W'(pop_src.size()), W'(3));

        // Source 1 runs dry after two words; source 0 becomes eligible mid-burst
        clear_all();
        src_en = 3'b011;
        load(1, 16'hD000, 2, 1'b1);
        step();
        load(0, 16'hE000, 1, 1'b1);
        drain(40, "t4");
        check("t4_pop_count", W'(pop_src.size()), W'(3));
        if (pop_src.size() == 3) begin
            check("t4_src_a", W'(pop_src[0]), W'(1));
            check("t4_src_b", W'(pop_src[1]), W'(1));
            check("t4_src_c", W'(pop_src[2]), W'(0));
            check("t4_gap_after_empty", W'(pop_cyc[2] - pop_cyc[1]), W'(3));
        end

        // Source 1 masked, sources 0 and 2 alternate; clear SRC_EN[0] mid-burst
        clear_all();
        sb_auto = 1'b1;
        src_en  = 3'b101;
        load(0, 16'h5000, 10, 1'b0);
        load(1, 16'h5100, 10, 1'b0);
        load(2, 16'h5200, 10, 1'b0);
        n = 0;
        while (pop_src.size() < 14 && n < 40) begin
            step();
            n++;
        end
        check("t5_reached_14_pops", W'(pop_src.size()), W'(14));
        for (int k = 0; k < 14; k++) begin
            check($sformatf("t5_pop_src_%0d", k), W'(k < pop_src.size() ? pop_src[k] : 99), W'(e5[k]));
        end
        #1;
        check("t5_src0_active", W'(src_read), W'(3'b001));
        src_en = 3'b100;
        #1;
        check("t5_src0_masked", W'(src_read), W'(3'b000));
        repeat (8) step();
        src_en = '0;
        drain(40, "t5");
        nsrc1 = 0;
        foreach (pop_src[k]) if (pop_src[k] == 1) nsrc1++;
        check("t5_src1_never_read", W'(nsrc1), W'(0));
        sb_auto = 1'b0;

        // Consumer pops on an empty queue, then steady push+pop at count 1
        clear_all();
        fifo_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t6_empty_pulse_%0d", k), W'(fifo_empty), W'(1'b1));
        end
        src_en = 3'b001;
        load(0, 16'hF000, 4, 1'b1);
        step();
        step();
        step();
        check("t6_head_advanced", fifo_data, 16'hF001);
        check("t6_not_empty", W'(fifo_empty), W'(1'b0));
        drain(40, "t6");
        check("t6_scoreboard_drained", W'(exp_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
